// File: rtl/spi_master_ctrl.sv
// SPI master for 1..8 byte transactions in any SPI mode, with a one-deep
// next-byte buffer so consecutive bytes can stream without a clock gap.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_vd,
  input  logic [7:0] i_tx_data,
  input  logic [2:0] i_num_bytes,
  input  logic       i_cpol,
  input  logic       i_cpha,
  output logic       o_tx_ready,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  output logic       o_leading_edge,
  output logic       o_trailing_edge,
  output logic [2:0] o_bit_count,
  output logic [2:0] o_byte_count,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned   CW         = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_RELOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_ONE    = CW'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] div_cnt;
  logic          armed;
  logic          sclk_q;
  logic          mosi_q;
  logic          lead_q;
  logic          trail_q;
  logic          done_q;
  logic          cpol_q;
  logic          cpha_q;
  logic [2:0]    num_q;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_cnt;
  logic [7:0]    tx_byte;
  logic [7:0]    nxt_byte;
  logic          buf_full;

  logic          tx_ready;
  logic          accept;
  logic          div_zero;
  logic          more_bytes;
  logic          lead_phase;
  logic          next_avail;
  logic [7:0]    next_src;
  logic [2:0]    cur_idx;
  logic [2:0]    nxt_idx;

  always_comb begin
    tx_ready = 1'b0;
    case (state)
      ST_IDLE: tx_ready = armed;
      ST_XFER: tx_ready = (bit_cnt == 3'd7) && more_bytes && !buf_full;
      ST_WAIT: tx_ready = !buf_full;
      default: tx_ready = 1'b0;
    endcase
  end

  assign accept     = i_tx_vd && tx_ready;
  assign div_zero   = (div_cnt == '0);
  assign more_bytes = (byte_cnt != num_q);
  // sclk back at its idle level means the next toggle is a leading edge
  assign lead_phase = (sclk_q == cpol_q);
  // a byte offered on the very edge that ends the current one still streams gap-free
  assign next_avail = buf_full || accept;
  assign next_src   = buf_full ? nxt_byte : i_tx_data;
  assign cur_idx    = 3'd7 - bit_cnt;
  assign nxt_idx    = 3'd6 - bit_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      armed    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      done_q   <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      num_q    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_byte  <= '0;
      nxt_byte <= '0;
      buf_full <= 1'b0;
    end else begin
      armed   <= 1'b1;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk_q <= i_cpol;
          if (accept) begin
            tx_byte  <= i_tx_data;
            num_q    <= i_num_bytes;
            cpol_q   <= i_cpol;
            cpha_q   <= i_cpha;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            buf_full <= 1'b0;
            div_cnt  <= DIV_RELOAD;
            if (!i_cpha) mosi_q <= i_tx_data[7];
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (div_zero) begin
            div_cnt <= DIV_RELOAD;
            state   <= ST_XFER;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end

        ST_XFER: begin
          if (accept) begin
            nxt_byte <= i_tx_data;
            buf_full <= 1'b1;
          end
          if (!div_zero) begin
            div_cnt <= div_cnt - DIV_ONE;
          end else begin
            div_cnt <= DIV_RELOAD;
            sclk_q  <= ~sclk_q;
            if (lead_phase) begin
              lead_q <= 1'b1;
              if (cpha_q) mosi_q <= tx_byte[cur_idx];
            end else begin
              trail_q <= 1'b1;
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (!cpha_q) mosi_q <= tx_byte[nxt_idx];
              end else begin
                bit_cnt <= '0;
                if (!more_bytes) begin
                  state <= ST_HOLD;
                end else begin
                  byte_cnt <= byte_cnt + 3'd1;
                  if (next_avail) begin
                    tx_byte  <= next_src;
                    buf_full <= 1'b0;
                    if (!cpha_q) mosi_q <= next_src[7];
                  end else begin
                    state <= ST_WAIT;
                  end
                end
              end
            end
          end
        end

        // the leading edge of the resumed byte is issued here, CLK_DIV cycles after the byte arrives
        ST_WAIT: begin
          if (accept) begin
            nxt_byte <= i_tx_data;
            buf_full <= 1'b1;
            div_cnt  <= DIV_RELOAD;
            if (!cpha_q) mosi_q <= i_tx_data[7];
          end else if (buf_full) begin
            if (div_zero) begin
              tx_byte  <= nxt_byte;
              buf_full <= 1'b0;
              div_cnt  <= DIV_RELOAD;
              sclk_q   <= ~sclk_q;
              lead_q   <= 1'b1;
              if (cpha_q) mosi_q <= nxt_byte[7];
              state    <= ST_XFER;
            end else begin
              div_cnt <= div_cnt - DIV_ONE;
            end
          end
        end

        ST_HOLD: begin
          if (div_zero) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx_ready      = tx_ready;
  assign o_busy          = (state != ST_IDLE);
  assign o_cs_n          = (state == ST_IDLE);
  assign o_sclk          = (state == ST_IDLE) ? (i_cpol && armed) : sclk_q;
  assign o_mosi          = mosi_q;
  assign o_leading_edge  = lead_q;
  assign o_trailing_edge = trail_q;
  assign o_bit_count     = bit_cnt;
  assign o_byte_count    = byte_cnt;
  assign o_done          = done_q;

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning i_clk cycles per SCK half-period; legal range 1..255.
REQ-002 SHALL have port i_clk, input, 1, system clock; every flop is rising-edge.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port i_tx_vd, input, 1, byte-valid strobe qualifying i_tx_data.
REQ-005 SHALL have port i_tx_data, input, 8, byte to transmit, MSB first.
REQ-006 SHALL have port i_num_bytes, input, 3, transaction length minus 1 (0..7), sampled at start.
REQ-007 SHALL have ports i_cpol and i_cpha, input, 1 each, SPI mode, sampled at start.
REQ-008 SHALL have port o_tx_ready, output, 1, block can accept a byte this cycle.
REQ-009 SHALL have ports o_sclk, o_cs_n and o_mosi, output, 1 each, SPI bus.
REQ-010 SHALL have ports o_leading_edge and o_trailing_edge, output, 1 each, one-cycle pulses coincident with the o_sclk toggle.
REQ-011 SHALL have ports o_bit_count and o_byte_count, output, 3 each, position in the transaction.
REQ-012 SHALL have ports o_busy and o_done, output, 1 each; o_done is a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, XFER, WAIT, HOLD.
REQ-014 IDLE SHALL drive o_tx_ready=1, o_busy=0, o_cs_n=1 and o_sclk=i_cpol (live).
REQ-015 In IDLE, i_tx_vd=1 SHALL latch i_tx_data, i_num_bytes, i_cpol and i_cpha, clear both counters, and go to SETUP on the next cycle.
REQ-016 SETUP SHALL drive o_cs_n=0 for exactly CLK_DIV cycles, with o_mosi=data[7] when cpha=0, then go to XFER.
REQ-017 XFER SHALL toggle o_sclk every CLK_DIV cycles, giving 16 toggles per byte; odd toggles SHALL pulse o_leading_edge and even toggles SHALL pulse o_trailing_edge.
REQ-018 When cpha=0, the block SHALL shift o_mosi to the next bit on the trailing edge; the slave samples on the leading edge.
REQ-019 When cpha=1, the block SHALL shift o_mosi on the leading edge; the slave samples on the trailing edge.
REQ-020 o_bit_count SHALL increment on each trailing edge, wrapping 7->0 at byte end.
REQ-021 At byte end, o_byte_count SHALL increment when more bytes remain, or hold its value when the byte was the last.
REQ-022 o_bit_count=7 together with o_byte_count=i_num_bytes SHALL identify the final bit, matching the receive shift register's capture condition.
REQ-023 During XFER, o_tx_ready SHALL be 1 only while bit_count=7 and more bytes remain and no next byte is yet buffered.
REQ-024 i_tx_vd with o_tx_ready=1 SHALL load a one-deep next-byte buffer.
REQ-025 At byte end with the buffer full, the next byte SHALL start on the following half-period with no gap.
REQ-026 At byte end with the buffer empty, the block SHALL go to WAIT.
REQ-027 WAIT SHALL hold o_sclk at cpol, keep o_cs_n=0 and o_tx_ready=1, and return to XFER CLK_DIV cycles after i_tx_vd.
REQ-028 After the final trailing edge, the block SHALL go to HOLD, keep o_cs_n=0 for CLK_DIV cycles, then set o_cs_n=1, pulse o_done, and return to IDLE.
REQ-029 o_busy SHALL be 1 in every state except IDLE.
REQ-030 i_tx_vd while o_tx_ready=0 SHALL be ignored, and the latched data and mode SHALL not change.
REQ-031 Changes on i_cpol, i_cpha or i_num_bytes while busy SHALL have no effect.
REQ-032 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide and reload to CLK_DIV-1 on every toggle.

Reset
REQ-033 i_rst=0 at a rising i_clk edge SHALL force IDLE from any state, including mid-transfer, in that cycle.
REQ-034 Reset values SHALL be: o_cs_n=1, o_sclk=0, o_mosi=0, edge pulses 0, counters 0, o_busy=0, o_done=0, o_tx_ready=0, and the next-byte buffer empty.
REQ-035 o_tx_ready SHALL rise in the first cycle after reset is released.
REQ-036 o_sclk SHALL follow i_cpol from the first cycle after reset is released.

Verification
REQ-037 Mode 0, CLK_DIV=2, one byte 0xA5: o_mosi=1,0,1,0,0,1,0,1 at the eight leading edges; cs_n low for 2+32+2 cycles; o_done pulses once.
REQ-038 Mode 3, CLK_DIV=1, three bytes 0x01,0x80,0xFF supplied back-to-back: 48 contiguous sclk toggles, idle-high clock, byte_count ends at 2.
REQ-039 Two bytes with the second supplied 10 cycles late: WAIT holds sclk=cpol and cs_n=0; transfer resumes CLK_DIV cycles after i_tx_vd.
REQ-040 i_rst=0 during bit 4 of byte 1: next cycle cs_n=1, busy=0, counters 0, no o_done pulse.
REQ-041 i_tx_vd while busy and o_tx_ready=0, value 0x3C: the transmitted stream is unchanged and 0x3C is never sent.
REQ-042 i_num_bytes=7: eight bytes sent; the o_bit_count=7 with o_byte_count=7 condition occurs exactly once before o_done.
